// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with 8-byte packing buffer, optional even parity (UART_RX_PARITY_EN)
// rx is synchronized, oversampled at mid-bit, and accepted bytes are packed first-byte-at-[7:0].
module uart_rx #(
    parameter int CLOCK_PER_BAUD_RATE = 5208,
    parameter int HALF_BIT            = CLOCK_PER_BAUD_RATE / 2
) (
    input  logic        CLOCK_50M,
    input  logic        RESET,
    input  logic        RX,
    input  logic        buffer_clear,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic [63:0] rx_buffer_out,
    output logic [3:0]  rx_buffer_count_out,
    output logic        frame_error,
    output logic        overrun,
`ifdef UART_RX_PARITY_EN
    output logic        parity_error,
`endif
    output logic        busy
);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif

    localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);
    localparam logic [15:0] BIT_LAST  = 16'(CLOCK_PER_BAUD_RATE - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        sync1, rxs;
    logic        accept, ferr, push;
`ifdef UART_RX_PARITY_EN
    logic        par_q, par_d;
    logic        perr;
`endif

    assign busy = (state_q != IDLE);

    always_ff @(posedge CLOCK_50M) begin
        if (RESET) begin
            sync1   <= 1'b1;
            rxs     <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            sync1   <= RX;
            rxs     <= sync1;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        accept  = 1'b0;
        ferr    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    idx_d = '0;
                    // a start bit that has vanished by mid-bit was line noise
                    state_d = rxs ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rxs;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    par_d   = rxs;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rxs) begin
                        accept  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr    = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            WAIT_HIGH: begin
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    assign perr = ^{shift_q, par_q};
    assign push = accept && !perr;
`else
    assign push = accept;
`endif

    always_ff @(posedge CLOCK_50M) begin
        if (RESET) begin
            rx_data             <= '0;
            rx_valid            <= 1'b0;
            rx_buffer_out       <= '0;
            rx_buffer_count_out <= '0;
            frame_error         <= 1'b0;
            overrun             <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error        <= 1'b0;
`endif
        end else begin
            rx_valid    <= accept;
            frame_error <= ferr;
`ifdef UART_RX_PARITY_EN
            parity_error <= accept && perr;
`endif
            if (accept) rx_data <= shift_q;
            // clear wins over stored contents but never drops the byte arriving with it
            if (buffer_clear) begin
                overrun <= 1'b0;
                if (push) begin
                    rx_buffer_out       <= {56'd0, shift_q};
                    rx_buffer_count_out <= 4'd1;
                end else begin
                    rx_buffer_out       <= '0;
                    rx_buffer_count_out <= '0;
                end
            end else if (push) begin
                if (rx_buffer_count_out[3]) begin
                    overrun <= 1'b1;
                end else begin
                    rx_buffer_out[{rx_buffer_count_out[2:0], 3'b000} +: 8] <= shift_q;
                    rx_buffer_count_out <= rx_buffer_count_out + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at 16 clocks per bit
module tb_uart_rx;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_EXTRA = CPB;
`else
    localparam int PAR_EXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        RESET;
    logic        RX;
    logic        buffer_clear;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [63:0] rx_buffer_out;
    logic [3:0]  rx_buffer_count_out;
    logic        frame_error;
    logic        overrun;
    logic        busy;
`ifdef UART_RX_PARITY_EN
    logic        parity_error;
`endif

    int checks = 0;
    int errors = 0;
    int ferr_seen = 0;
    logic [7:0] exp_q[$];

    always #10 clk = ~clk;

    uart_rx #(.CLOCK_PER_BAUD_RATE(CPB), .HALF_BIT(CPB / 2)) dut (
        .CLOCK_50M(clk),
        .RESET(RESET),
        .RX(RX),
        .buffer_clear(buffer_clear),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_buffer_out(rx_buffer_out),
        .rx_buffer_count_out(rx_buffer_count_out),
        .frame_error(frame_error),
        .overrun(overrun),
`ifdef UART_RX_PARITY_EN
        .parity_error(parity_error),
`endif
        .busy(busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (frame_error === 1'b1) ferr_seen++;
        if (rx_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rx_valid: got 0x%0h expected no byte", rx_data);
            end else begin
                check("rx_data_scoreboard", {56'd0, rx_data}, {56'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic v);
        RX = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^b);
`endif
        send_bit(stop);
    endtask

    task automatic pulse_clear();
        buffer_clear = 1'b1;
        @(negedge clk);
        buffer_clear = 1'b0;
    endtask

    initial begin
        RX = 1'b1;
        RESET = 1'b1;
        buffer_clear = 1'b0;
        idle(3);
        RESET = 1'b0;
        idle(1);
        check("reset_rx_data", {56'd0, rx_data}, 64'd0);
        check("reset_rx_valid", {63'd0, rx_valid}, 64'd0);
        check("reset_buffer", rx_buffer_out, 64'd0);
        check("reset_count", {60'd0, rx_buffer_count_out}, 64'd0);
        check("reset_overrun", {63'd0, overrun}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_frame_error", {63'd0, frame_error}, 64'd0);

        // single byte
        exp_q.push_back(8'h41);
        send_byte(8'h41, 1'b1);
        idle(20);
        check("t1_count", {60'd0, rx_buffer_count_out}, 64'd1);
        check("t1_buffer", rx_buffer_out, 64'h41);
        check("t1_no_frame_error", ferr_seen, 0);

        // short glitch
        pulse_clear();
        RX = 1'b0;
        idle(3);
        check("t2_glitch_busy", {63'd0, busy}, 64'd1);
        RX = 1'b1;
        idle(20);
        check("t2_busy_after", {63'd0, busy}, 64'd0);
        check("t2_count", {60'd0, rx_buffer_count_out}, 64'd0);

        // framing error then a good byte
        send_byte(8'h55, 1'b0);
        RX = 1'b0;
        idle(40);
        RX = 1'b1;
        idle(20);
        exp_q.push_back(8'hA3);
        send_byte(8'hA3, 1'b1);
        idle(20);
        check("t3_frame_errors", ferr_seen, 1);
        check("t3_count", {60'd0, rx_buffer_count_out}, 64'd1);
        check("t3_buffer", rx_buffer_out, 64'hA3);

        // nine back-to-back bytes
        pulse_clear();
        for (int i = 1; i <= 9; i++) begin
            exp_q.push_back(8'(i));
            send_byte(8'(i), 1'b1);
        end
        idle(20);
        check("t4_buffer", rx_buffer_out, 64'h0807060504030201);
        check("t4_count", {60'd0, rx_buffer_count_out}, 64'd8);
        check("t4_overrun", {63'd0, overrun}, 64'd1);
        check("t4_rx_data", {56'd0, rx_data}, 64'h09);

        // clear coincident with push
        exp_q.push_back(8'h77);
        fork
            send_byte(8'h77, 1'b1);
            begin
                repeat (154 + PAR_EXTRA) @(negedge clk);
                buffer_clear = 1'b1;
                @(negedge clk);
                buffer_clear = 1'b0;
            end
        join
        idle(20);
        check("t5_count", {60'd0, rx_buffer_count_out}, 64'd1);
        check("t5_buffer", rx_buffer_out, 64'h77);
        check("t5_overrun", {63'd0, overrun}, 64'd0);

        // reset mid-DATA
        fork
            send_byte(8'hF8, 1'b1);
            begin
                repeat (88) @(negedge clk);
                RESET = 1'b1;
                @(negedge clk);
                RESET = 1'b0;
                @(negedge clk);
                check("t6_rx_data", {56'd0, rx_data}, 64'd0);
                check("t6_buffer", rx_buffer_out, 64'd0);
                check("t6_count", {60'd0, rx_buffer_count_out}, 64'd0);
                check("t6_overrun", {63'd0, overrun}, 64'd0);
                check("t6_busy", {63'd0, busy}, 64'd0);
            end
        join
        idle(5);
        exp_q.push_back(8'hC3);
        send_byte(8'hC3, 1'b1);
        idle(20);
        check("t6_count_after", {60'd0, rx_buffer_count_out}, 64'd1);
        check("t6_buffer_after", rx_buffer_out, 64'hC3);
        check("t6_rx_data_after", {56'd0, rx_data}, 64'hC3);

        check("total_frame_errors", ferr_seen, 1);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver: the receive-side counterpart of the team's serial transmitter; same 50 MHz clock and same bit period.
- Oversamples RX with the system clock and recovers bytes, LSB first.
- Pushes each byte into a 64-bit, 8-byte packing buffer. The first byte received sits in bits [7:0], matching the byte order the transmitter consumes.
- Flags framing and overrun errors for the downstream command logic.

Parameters:
- CLOCK_PER_BAUD_RATE, 5208: CLOCK_50M cycles per bit (9600 baud at 50 MHz); must be >= 4.
- HALF_BIT, CLOCK_PER_BAUD_RATE/2: cycle offset from start-edge detect to the start-bit mid-sample.

Ports:
- CLOCK_50M  input  1  system clock; all logic on its rising edge.
- RESET  input  1  synchronous reset, active-high.
- RX  input  1  asynchronous serial line; idle high.
- buffer_clear  input  1  one-cycle pulse; empties the receive buffer.
- rx_data  output  8  last valid byte received.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- rx_buffer_out  output  64  packed bytes; byte k occupies [8k+7:8k].
- rx_buffer_count_out  output  4  number of valid bytes in buffer, 0..8.
- frame_error  output  1  one-cycle pulse when a stop bit is sampled low.
- overrun  output  1  sticky; set when a byte arrives with the buffer full.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset: state IDLE, both synchronizer flops = 1, counters 0, rx_data = 0, rx_valid = 0, rx_buffer_out = 0, count = 0, frame_error = 0, overrun = 0.
- Reset mid-frame aborts the frame; no partial byte is stored.
- RX passes through a two-flop synchronizer to give rxs. rxs lags RX by 2 cycles. All decisions use rxs only.
- 16-bit cycle counter cnt; 3-bit bit index idx.
- IDLE: when rxs == 0, go to START with cnt = 0.
- START: cnt increments. At cnt == HALF_BIT-1, sample rxs:
  - rxs == 0: go to DATA, cnt = 0, idx = 0.
  - rxs == 1: glitch; go to IDLE, nothing flagged.
- DATA: cnt increments. At cnt == CLOCK_PER_BAUD_RATE-1, sample rxs into shift register bit idx and set cnt = 0. After idx 7 is sampled, go to STOP (or PARITY when the optional feature is compiled in).
- STOP: at cnt == CLOCK_PER_BAUD_RATE-1, sample rxs:
  - 1: byte accepted; go to IDLE.
  - 0: frame_error pulses on the next cycle; byte discarded; go to WAIT_HIGH.
- WAIT_HIGH: stay until rxs == 1, then go to IDLE. This prevents a break condition from being taken as a start bit.
- Accepted byte, on the cycle after the stop sample:
  - rx_data <= byte; rx_valid = 1 for exactly one cycle.
  - If count < 8: byte written to rx_buffer_out[8*count +: 8], count + 1.
  - If count == 8: buffer unchanged, overrun <= 1.
- overrun clears only on RESET or buffer_clear.
- buffer_clear: count <= 0, rx_buffer_out <= 0, overrun <= 0.
- buffer_clear on the same cycle as a push: clear first, then push. Byte lands at [7:0], count = 1, overrun = 0.
- Latency: rx_valid asserts 2 + HALF_BIT + 9*CLOCK_PER_BAUD_RATE + 1 cycles after the RX falling edge, ±1 for edge-detect alignment.
- A new start bit is accepted in the cycle right after returning to IDLE, so back-to-back frames with no idle gap are received.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Extra state PARITY between DATA and STOP samples one even-parity bit.
  - Output parity_error (1 bit) pulses on the accept cycle if XOR(data, parity bit) != 0.
  - A byte with a parity error is still delivered to rx_data/rx_valid but is not pushed into the buffer.
- Undefined: no PARITY state, no parity_error port; frame is 8N1.

Test Plan (CLOCK_PER_BAUD_RATE = 16 in simulation):
- Send 8N1 byte 0x41 after reset → one rx_valid pulse; rx_data = 0x41; rx_buffer_out[7:0] = 0x41; count = 1; frame_error never high.
- RX low for 3 cycles then high (glitch shorter than HALF_BIT) → return to IDLE; no rx_valid; busy deasserts; count stays 0.
- Send 0x55 with the stop bit held low, line held low 40 cycles, then high, then 0xA3 → frame_error pulses once; 0x55 not stored; 0xA3 received correctly; count = 1.
- Send 9 back-to-back bytes 0x01..0x09 with no idle gap → rx_buffer_out = 0x0807060504030201; count = 8; overrun = 1; rx_data = 0x09.
- Complete 0x77 arriving on the same cycle as a buffer_clear pulse, with 8 bytes stored → count = 1; rx_buffer_out = 0x0000000000000077; overrun = 0.
- RESET asserted for 1 cycle mid-DATA of a frame → all outputs at reset values; the next full frame 0xC3 is received correctly.
